// File: rtl/wb_pkg.sv
// Shared constants for the writeback stage: load-type codes, the hard-wired
// zero register index and default datapath widths.
package wb_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/wb_writeback_load_align.sv
// Little-endian load alignment: picks the byte/halfword lane of a raw memory
// word and sign- or zero-extends it to the datapath width.
module load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic [2:0]        ld_type,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] data
);

  function automatic logic [DATA_W-1:0] ext8(input logic signed [7:0] v, input logic sgn);
    return {{(DATA_W-8){sgn & v[7]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] ext16(input logic signed [15:0] v, input logic sgn);
    return {{(DATA_W-16){sgn & v[15]}}, v};
  endfunction

  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  // Lane extraction and extension; halfword lane ignores addr_lo[0]
  always_comb begin
    lane_b = word[{addr_lo, 3'b000} +: 8];
    lane_h = word[{addr_lo[1], 4'b0000} +: 16];
    case (ld_type)
      LD_LB:   data = ext8(lane_b, 1'b1);
      LD_LBU:  data = ext8(lane_b, 1'b0);
      LD_LH:   data = ext16(lane_h, 1'b1);
      LD_LHU:  data = ext16(lane_h, 1'b0);
      default: data = word;
    endcase
  end

endmodule

// File: rtl/wb_writeback.sv
// Writeback stage: one MEM/WB register fed by a valid/ready handshake, the
// register-file write port driven from it, operand forwarding of the pending
// write into decode, and a wrapping retired-instruction counter.
module wb_writeback
  import wb_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_regwrite,
  input  logic [ADDR_W-1:0]   in_rd,
  input  logic                in_memtoreg,
  input  logic [DATA_W-1:0]   in_alu_result,
  input  logic [DATA_W-1:0]   in_mem_data,
  input  logic [2:0]          in_ld_type,
  input  logic [1:0]          in_addr_lo,
  input  logic                flush,
  input  logic                wb_hold,
  input  logic [ADDR_W-1:0]   rs,
  input  logic [ADDR_W-1:0]   rt,
  input  logic [DATA_W-1:0]   rf_readdat1,
  input  logic [DATA_W-1:0]   rf_readdat2,
  output logic [DATA_W-1:0]   A_fwd,
  output logic [DATA_W-1:0]   B_fwd,
  output logic                regwrite,
  output logic [ADDR_W-1:0]   rd,
  output logic [DATA_W-1:0]   writedata,
  output logic [RETIRE_W-1:0] retired_count
);

  logic                s_valid_q, s_valid_d;
  logic                s_we_q,    s_we_d;
  logic [ADDR_W-1:0]   s_rd_q,    s_rd_d;
  logic [DATA_W-1:0]   s_data_q,  s_data_d;
  logic [RETIRE_W-1:0] count_q,   count_d;

  logic [DATA_W-1:0]   ld_data;
  logic [DATA_W-1:0]   sel_data;
  logic                xfer;
  logic                live;

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .ld_type (in_ld_type),
    .addr_lo (in_addr_lo),
    .word    (in_mem_data),
    .data    (ld_data)
  );

  // Handshake, result select and the pending-write qualifier
  always_comb begin
    in_ready = ~wb_hold;
    xfer     = in_valid & in_ready & ~flush;
    sel_data = in_memtoreg ? ld_data : in_alu_result;
    live     = s_valid_q & s_we_q & (s_rd_q != ADDR_W'(ZERO_REG));
  end

  // Next-state of the MEM/WB register and retire counter
  always_comb begin
    s_valid_d = s_valid_q;
    s_we_d    = s_we_q;
    s_rd_d    = s_rd_q;
    s_data_d  = s_data_q;
    count_d   = count_q;
    if (!wb_hold) begin
      count_d = count_q + RETIRE_W'(s_valid_q);
      if (xfer) begin
        s_valid_d = 1'b1;
        s_we_d    = in_regwrite;
        s_rd_d    = in_rd;
        s_data_d  = sel_data;
      end else begin
        s_valid_d = 1'b0;
      end
    end
  end

  // ---- MEM/WB register boundary ----
  // State update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_valid_q <= 1'b0;
      s_we_q    <= 1'b0;
      s_rd_q    <= '0;
      s_data_q  <= '0;
      count_q   <= '0;
    end else begin
      s_valid_q <= s_valid_d;
      s_we_q    <= s_we_d;
      s_rd_q    <= s_rd_d;
      s_data_q  <= s_data_d;
      count_q   <= count_d;
    end
  end

  // Write issue and forwarding; forwarding stays active under hold
  always_comb begin
    regwrite      = live & ~wb_hold;
    rd            = s_rd_q;
    writedata     = s_data_q;
    retired_count = count_q;
    A_fwd         = (live && (s_rd_q == rs)) ? s_data_q : rf_readdat1;
    B_fwd         = (live && (s_rd_q == rt)) ? s_data_q : rf_readdat2;
  end

endmodule

// File: tb/tb_wb_writeback.sv
// Directed bench for wb_writeback, instantiated with a 4-bit retire counter.
module tb_wb_writeback;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_regwrite, in_memtoreg;
  logic [AW-1:0] in_rd;
  logic [DW-1:0] in_alu_result, in_mem_data;
  logic [2:0]    in_ld_type;
  logic [1:0]    in_addr_lo;
  logic          flush, wb_hold;
  logic [AW-1:0] rs, rt;
  logic [DW-1:0] rf_readdat1, rf_readdat2, A_fwd, B_fwd;
  logic          regwrite;
  logic [AW-1:0] rd;
  logic [DW-1:0] writedata;
  logic [RW-1:0] retired_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_writeback #(.DATA_W(DW), .ADDR_W(AW), .RETIRE_W(RW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_regwrite(in_regwrite), .in_rd(in_rd), .in_memtoreg(in_memtoreg),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
    .in_ld_type(in_ld_type), .in_addr_lo(in_addr_lo), .flush(flush),
    .wb_hold(wb_hold), .rs(rs), .rt(rt), .rf_readdat1(rf_readdat1),
    .rf_readdat2(rf_readdat2), .A_fwd(A_fwd), .B_fwd(B_fwd),
    .regwrite(regwrite), .rd(rd), .writedata(writedata),
    .retired_count(retired_count)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [AW-1:0] r,
                       input logic m2r, input logic [DW-1:0] alu,
                       input logic [2:0] lt, input logic [1:0] lo);
    in_valid = v; in_regwrite = we; in_rd = r; in_memtoreg = m2r;
    in_alu_result = alu; in_ld_type = lt; in_addr_lo = lo;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; wb_hold = 1'b0;
    rs = 5'd7; rt = 5'd0; rf_readdat1 = 32'h55; rf_readdat2 = 32'h0;
    in_mem_data = 32'h0;
    drive(1'b1, 1'b1, 5'd7, 1'b0, 32'h1, 3'd0, 2'd0);
    repeat (5) cycle();
    checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL rst_we got=%0b want=0", regwrite); end
    checks++; if (retired_count !== 4'd0) begin errors++; $display("FAIL rst_cnt got=%0d want=0", retired_count); end
    checks++; if (rd !== 5'd0 || writedata !== 32'h0) begin errors++; $display("FAIL rst_out got rd=%0d wd=%h want 0/0", rd, writedata); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%0b want=1", in_ready); end
    checks++; if (A_fwd !== 32'h55) begin errors++; $display("FAIL rst_fwd got=%h want=00000055", A_fwd); end
    rst = 1'b1;
    cycle();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 3'd0, 2'd0);
    #1;
    checks++; if (regwrite !== 1'b1 || rd !== 5'd7 || writedata !== 32'h1) begin errors++; $display("FAIL rel_write got we=%0b rd=%0d wd=%h want 1/7/00000001", regwrite, rd, writedata); end
    cycle();
    checks++; if (regwrite !== 1'b0 || retired_count !== 4'd1) begin errors++; $display("FAIL rel_after got we=%0b cnt=%0d want 0/1", regwrite, retired_count); end
  endtask

  task automatic test_alu_write();
    drive(1'b1, 1'b1, 5'd2, 1'b0, 32'hAAAAAAAA, 3'd0, 2'd0);
    cycle();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 3'd0, 2'd0);
    rs = 5'd2; rf_readdat1 = 32'h0; rt = 5'd3; rf_readdat2 = 32'h33;
    #1;
    checks++; if (regwrite !== 1'b1 || rd !== 5'd2 || writedata !== 32'hAAAAAAAA) begin errors++; $display("FAIL alu_write got we=%0b rd=%0d wd=%h want 1/2/aaaaaaaa", regwrite, rd, writedata); end
    checks++; if (A_fwd !== 32'hAAAAAAAA) begin errors++; $display("FAIL alu_fwdA got=%h want=aaaaaaaa", A_fwd); end
    checks++; if (B_fwd !== 32'h33) begin errors++; $display("FAIL alu_fwdB got=%h want=00000033", B_fwd); end
    cycle();
    checks++; if (retired_count !== 4'd2) begin errors++; $display("FAIL alu_cnt got=%0d want=2", retired_count); end
  endtask

  task automatic test_loads();
    logic [2:0]  lt  [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
    logic [1:0]  lo  [6] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd1};
    logic [31:0] exp [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                             32'h00007F01, 32'h80FF7F01, 32'h0000007F};
    in_mem_data = 32'h80FF7F01;
    drive(1'b1, 1'b1, 5'd9, 1'b1, 32'hDEADBEEF, lt[0], lo[0]);
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (i < 5) drive(1'b1, 1'b1, 5'd9, 1'b1, 32'hDEADBEEF, lt[i+1], lo[i+1]);
      else       drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 3'd0, 2'd0);
      #1;
      checks++; if (regwrite !== 1'b1 || writedata !== exp[i]) begin errors++; $display("FAIL load%0d got we=%0b wd=%h want 1/%h", i, regwrite, writedata, exp[i]); end
    end
    cycle();
    checks++; if (retired_count !== 4'd8 || regwrite !== 1'b0) begin errors++; $display("FAIL load_cnt got cnt=%0d we=%0b want 8/0", retired_count, regwrite); end
  endtask

  task automatic test_zero_reg();
    drive(1'b1, 1'b1, 5'd0, 1'b0, 32'h12345678, 3'd0, 2'd0);
    cycle();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 3'd0, 2'd0);
    rs = 5'd0; rf_readdat1 = 32'h0000DEAD;
    #1;
    checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL zero_we got=%0b want=0", regwrite); end
    checks++; if (A_fwd !== 32'h0000DEAD) begin errors++; $display("FAIL zero_fwd got=%h want=0000dead", A_fwd); end
    cycle();
    checks++; if (retired_count !== 4'd9) begin errors++; $display("FAIL zero_cnt got=%0d want=9", retired_count); end
  endtask

  task automatic test_hold();
    drive(1'b1, 1'b1, 5'd5, 1'b0, 32'h5555, 3'd0, 2'd0);
    cycle();
    wb_hold = 1'b1;
    drive(1'b1, 1'b1, 5'd6, 1'b0, 32'h6666, 3'd0, 2'd0);
    rs = 5'd5; rf_readdat1 = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0 || regwrite !== 1'b0) begin errors++; $display("FAIL hold%0d got rdy=%0b we=%0b want 0/0", i, in_ready, regwrite); end
      checks++; if (A_fwd !== 32'h5555 || retired_count !== 4'd9) begin errors++; $display("FAIL hold_fwd%0d got fwd=%h cnt=%0d want 00005555/9", i, A_fwd, retired_count); end
      cycle();
    end
    wb_hold = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 3'd0, 2'd0);
    #1;
    checks++; if (regwrite !== 1'b1 || rd !== 5'd5 || writedata !== 32'h5555) begin errors++; $display("FAIL hold_rel got we=%0b rd=%0d wd=%h want 1/5/00005555", regwrite, rd, writedata); end
    cycle();
    checks++; if (regwrite !== 1'b0 || retired_count !== 4'd10) begin errors++; $display("FAIL hold_once got we=%0b cnt=%0d want 0/10", regwrite, retired_count); end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    drive(1'b1, 1'b1, 5'd4, 1'b0, 32'h44, 3'd0, 2'd0);
    cycle();
    flush = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 3'd0, 2'd0);
    #1;
    checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL flush_we got=%0b want=0", regwrite); end
    cycle();
    checks++; if (retired_count !== 4'd10) begin errors++; $display("FAIL flush_cnt got=%0d want=10", retired_count); end
    drive(1'b1, 1'b1, 5'd3, 1'b0, 32'h33, 3'd0, 2'd0);
    cycle();
    flush = 1'b1;
    drive(1'b1, 1'b1, 5'd4, 1'b0, 32'h44, 3'd0, 2'd0);
    #1;
    checks++; if (regwrite !== 1'b1 || rd !== 5'd3 || writedata !== 32'h33) begin errors++; $display("FAIL flush_pend got we=%0b rd=%0d wd=%h want 1/3/00000033", regwrite, rd, writedata); end
    cycle();
    flush = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 3'd0, 2'd0);
    #1;
    checks++; if (regwrite !== 1'b0 || retired_count !== 4'd11) begin errors++; $display("FAIL flush_drop got we=%0b cnt=%0d want 0/11", regwrite, retired_count); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 5'd8, 1'b0, 32'h88, 3'd0, 2'd0);
    cycle();
    rst = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 3'd0, 2'd0);
    cycle();
    rst = 1'b1;
    #1;
    checks++; if (regwrite !== 1'b0 || rd !== 5'd0 || writedata !== 32'h0 || retired_count !== 4'd0) begin errors++; $display("FAIL rst_mid got we=%0b rd=%0d wd=%h cnt=%0d want 0/0/0/0", regwrite, rd, writedata, retired_count); end
    cycle();
    checks++; if (regwrite !== 1'b0 || retired_count !== 4'd0) begin errors++; $display("FAIL rst_mid_after got we=%0b cnt=%0d want 0/0", regwrite, retired_count); end
  endtask

  task automatic test_back_to_back_wrap();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b1, 5'(i % 31 + 1), 1'b0, 32'(i), 3'd0, 2'd0);
      cycle();
    end
    checks++; if (retired_count !== 4'd0 || regwrite !== 1'b1 || writedata !== 32'd16) begin errors++; $display("FAIL b2b_16 got cnt=%0d we=%0b wd=%h want 0/1/00000010", retired_count, regwrite, writedata); end
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 3'd0, 2'd0);
    cycle();
    checks++; if (retired_count !== 4'd1) begin errors++; $display("FAIL wrap_cnt got=%0d want=1", retired_count); end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_loads();
    test_zero_reg();
    test_hold();
    test_flush();
    test_reset_mid();
    test_back_to_back_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_writeback.md
Name: wb_writeback

Overview:
- Writeback stage driving the register file write port (regwrite, rd, writedata); the producer side of the interface the decode stage reads.
- Accepts MEM-stage results over a valid/ready handshake, selects ALU result or aligned load data, holds them in one MEM/WB register, then issues the register-file write.
- Also forwards the pending write onto the decode-stage read operands and counts retired instructions.

Parameters:
DATA_W, 32, datapath width
ADDR_W, 5, register index width
RETIRE_W, 16, retired-instruction counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-low
in_valid  input  1  MEM stage presents an instruction
in_ready  output  1  stage accepts this cycle
in_regwrite  input  1  instruction writes a register
in_rd  input  ADDR_W  destination register
in_memtoreg  input  1  1 = load data, 0 = ALU result
in_alu_result  input  DATA_W  ALU result / effective address
in_mem_data  input  DATA_W  raw memory word
in_ld_type  input  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU
in_addr_lo  input  2  byte offset of the load
flush  input  1  drop this cycle's incoming transfer
wb_hold  input  1  freeze the stage; no write issued
rs  input  ADDR_W  decode read index A
rt  input  ADDR_W  decode read index B
rf_readdat1  input  DATA_W  raw register-file port A
rf_readdat2  input  DATA_W  raw register-file port B
A_fwd  output  DATA_W  forwarded operand A
B_fwd  output  DATA_W  forwarded operand B
regwrite  output  1  register-file write enable
rd  output  ADDR_W  register-file write index
writedata  output  DATA_W  register-file write data
retired_count  output  RETIRE_W  retired-instruction count

Behaviour:
- State: S_valid, S_we, S_rd, S_data, counter.
- Reset (rst==0 at a clk edge): S_valid=0, S_we=0, S_rd=0, S_data=0, counter=0.
- Outputs during and after reset: regwrite=0, rd=0, writedata=0, retired_count=0, in_ready=1.
- in_ready = ~wb_hold. It is purely combinational and is 1 even when S is empty.
- Capture rule:
  - Transfer occurs when in_valid & in_ready & ~flush.
  - On a transfer, at the next edge: S_valid=1, S_we=in_regwrite, S_rd=in_rd, S_data=selected data.
  - If not held and there is no transfer: S_valid=0 at the next edge.
  - If wb_hold: S keeps its value. in_valid is ignored because in_ready=0.
- Data select:
  - in_memtoreg=0: in_alu_result.
  - in_memtoreg=1: load_align output, little-endian.
  - LB/LBU: byte lane in_addr_lo.
  - LH/LHU: halfword lane in_addr_lo[1]; in_addr_lo[0] is ignored.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW and codes 5-7: full word.
- Write issue (combinational from S):
  - regwrite = S_valid & S_we & (S_rd!=0) & ~wb_hold.
  - rd = S_rd and writedata = S_data at all times.
  - Writes to register 0 are never issued.
- Latency: accepted on edge N, written by the register file on edge N+1. One write per cycle, full throughput.
- Forwarding:
  - A_fwd = S_data if (S_valid & S_we & S_rd!=0 & S_rd==rs); otherwise rf_readdat1. B_fwd likewise with rt and rf_readdat2.
  - Forwarding applies during wb_hold too, because the write is still pending.
- Retire:
  - Counter increments on each edge where S_valid & ~wb_hold, whether or not the instruction writes.
  - It wraps modulo 2^RETIRE_W without saturating.
- flush only suppresses the incoming capture. An instruction already in S still writes.
- flush together with wb_hold: S is held; flush has no further effect.
- Reset mid-operation: a pending S entry is discarded and no write is issued.

Decomposition:
- Shared package wb_pkg: LD_LW/LD_LB/LD_LBU/LD_LH/LD_LHU codes, ZERO_REG=5'd0, DATA_W/ADDR_W defaults.
- One sub-module, load_align (combinational): ld_type, addr_lo, word -> aligned data.

Test Plan:
- Reset: hold rst=0 for 5 cycles with in_valid=1 -> regwrite=0, retired_count=0, S empty. Release -> first transfer, then regwrite=1 one cycle later.
- ALU write: in_rd=2, in_alu_result=32'hAAAAAAAA, in_regwrite=1, in_memtoreg=0 -> next cycle regwrite=1, rd=2, writedata=32'hAAAAAAAA. With rs=2 and rf_readdat1=0 -> A_fwd=32'hAAAAAAAA.
- Loads with in_mem_data=32'h80FF7F01:
  - LB addr_lo=3 -> 32'hFFFFFF80.
  - LBU addr_lo=3 -> 32'h00000080.
  - LH addr_lo=2 -> 32'hFFFF80FF.
  - LHU addr_lo=0 -> 32'h00007F01.
  - LW -> 32'h80FF7F01.
- $0 suppression: in_rd=0, in_regwrite=1, data 32'h12345678 -> regwrite stays 0, A_fwd=rf_readdat1 for rs=0, retired_count increments by 1.
- Hold/flush:
  - Assert wb_hold for 3 cycles with S pending rd=5 -> in_ready=0, regwrite=0, A_fwd forwards for rs=5, counter frozen. Release -> a single write of rd=5.
  - flush with in_valid=1 -> no capture, no write the following cycle.
- Counter wrap: preload RETIRE_W=4 and run 17 back-to-back instructions -> retired_count=1.
